// File: rtl/dl_pkg.sv
// rtl/dl_pkg.sv - shared types and helpers for the dataflow deadlock monitor
//
// Purpose : FSM state encoding, matrix index helper and lowest-set-bit priority
//           function used by the monitor top and its closure step.
// Ports   : none (package).
package dl_pkg;

  localparam int MAX_PROC = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLOSE  = 2'd1,
    CHECK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  // Flat position of wait-for edge i->j in an n x n row-major matrix.
  function automatic int idx(input int i, input int j, input int n);
    return i * n + j;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [MAX_PROC-1:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = MAX_PROC - 1; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/dataflow_deadlock_monitor_if.sv
// rtl/dataflow_deadlock_monitor_if.sv - observation/report bundle of the deadlock monitor
//
// Purpose : groups the monitor's control, observed graph and report signals.
// Ports   : enable, clear, proc_blocked[N_PROC], wait_for[N_PROC*N_PROC] (to monitor);
//           busy, dl_detect, dl_members[N_PROC], dl_origin[IDX_W],
//           dl_cycle[32] when DL_TIMESTAMP_EN is defined (from monitor).
interface dataflow_deadlock_monitor_if #(
  parameter int N_PROC = 3,
  parameter int IDX_W  = $clog2(N_PROC)
) ();

  logic                       enable;
  logic                       clear;
  logic [N_PROC-1:0]          proc_blocked;
  logic [N_PROC*N_PROC-1:0]   wait_for;
  logic                       busy;
  logic                       dl_detect;
  logic [N_PROC-1:0]          dl_members;
  logic [IDX_W-1:0]           dl_origin;
`ifdef DL_TIMESTAMP_EN
  logic [31:0]                dl_cycle;
`endif

  modport master (
    output enable, clear, proc_blocked, wait_for,
`ifdef DL_TIMESTAMP_EN
    input  dl_cycle,
`endif
    input  busy, dl_detect, dl_members, dl_origin
  );

  modport slave (
    input  enable, clear, proc_blocked, wait_for,
`ifdef DL_TIMESTAMP_EN
    output dl_cycle,
`endif
    output busy, dl_detect, dl_members, dl_origin
  );

endinterface

// File: rtl/dl_closure_step.sv
// rtl/dl_closure_step.sv - one transitive-closure step: reach | (reach x adj)
//
// Purpose : combinational boolean matrix product (OR of ANDs) merged with the
//           current reachability, extending known paths by one edge.
// Ports   : i_reach[N*N], i_adj[N*N] in; o_reach[N*N] out.
module dl_closure_step
  import dl_pkg::*;
#(
  parameter int N_PROC = 3
) (
  input  logic [N_PROC*N_PROC-1:0] i_reach,
  input  logic [N_PROC*N_PROC-1:0] i_adj,
  output logic [N_PROC*N_PROC-1:0] o_reach
);

  always_comb begin
    o_reach = i_reach;
    for (int i = 0; i < N_PROC; i++) begin
      for (int j = 0; j < N_PROC; j++) begin
        for (int k = 0; k < N_PROC; k++) begin
          if (i_reach[idx(i, k, N_PROC)] && i_adj[idx(k, j, N_PROC)]) begin
            o_reach[idx(i, j, N_PROC)] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/dataflow_deadlock_monitor.sv
// rtl/dataflow_deadlock_monitor.sv - N-process wait-for-graph deadlock monitor
//
// Purpose : waits for the blocked-masked wait-for matrix to stay unchanged for
//           STABLE_CYCLES, computes its transitive closure over N_PROC-1 steps
//           and reports any cycle (self-loops included) as a sticky result.
// Ports   : clock (rising edge), reset (async, active-low),
//           bus (slave modport of dataflow_deadlock_monitor_if).
// Config  : DL_TIMESTAMP_EN adds a free-running cycle counter latched into
//           bus.dl_cycle on detection.
module dataflow_deadlock_monitor
  import dl_pkg::*;
#(
  parameter int N_PROC        = 3,
  parameter int STABLE_CYCLES = 16,
  parameter int IDX_W         = $clog2(N_PROC),
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input logic                         clock,
  input logic                         reset,
  dataflow_deadlock_monitor_if.slave  bus
);

  localparam int M_W    = N_PROC * N_PROC;
  localparam int STEP_W = $clog2(N_PROC);

  state_t              r_state;
  state_t              w_next;
  logic [M_W-1:0]      w_m;
  logic [M_W-1:0]      r_prev_m;
  logic [M_W-1:0]      r_adj;
  logic [M_W-1:0]      r_reach;
  logic [M_W-1:0]      w_reach_next;
  logic [CNT_W-1:0]    r_stab_cnt;
  logic [STEP_W-1:0]   r_step;
  logic [N_PROC-1:0]   w_diag;
  logic                w_busy;
  logic                w_stable_hit;
  logic                w_step_done;
  logic                w_abort;
  logic                r_dl_detect;
  logic [N_PROC-1:0]   r_dl_members;
  logic [IDX_W-1:0]    r_dl_origin;

  // Only edges out of currently blocked processes matter.
  always_comb begin
    w_m = '0;
    for (int i = 0; i < N_PROC; i++) begin
      for (int j = 0; j < N_PROC; j++) begin
        w_m[idx(i, j, N_PROC)] = bus.wait_for[idx(i, j, N_PROC)] & bus.proc_blocked[i];
      end
    end
  end

  always_comb begin
    w_diag = '0;
    for (int i = 0; i < N_PROC; i++) begin
      w_diag[i] = r_reach[idx(i, i, N_PROC)];
    end
  end

  dl_closure_step #(.N_PROC(N_PROC)) u_step (
    .i_reach (r_reach),
    .i_adj   (r_adj),
    .o_reach (w_reach_next)
  );

  assign w_stable_hit = (r_stab_cnt == CNT_W'(STABLE_CYCLES - 1)) && (w_m != '0) && bus.enable;
  assign w_step_done  = (r_step == STEP_W'(N_PROC - 2));
  // Any change of the live graph while closing means some process made progress.
  assign w_abort      = (w_m != r_adj);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!bus.enable) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_stable_hit) w_next = CLOSE;
        CLOSE:   if (w_abort) w_next = IDLE;
                 else if (w_step_done) w_next = CHECK;
        CHECK:   if (bus.clear) w_next = IDLE;
                 else if (w_diag != '0) w_next = LOCKED;
                 else w_next = IDLE;
        LOCKED:  if (bus.clear) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy = (r_state == CLOSE) || (r_state == CHECK);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prev_m   <= '0;
      r_stab_cnt <= '0;
    end else begin
      r_prev_m <= w_m;
      if (!bus.enable || (r_state == CLOSE && w_abort) || (r_state == CHECK) ||
          (w_m != r_prev_m) || (w_m == '0)) begin
        r_stab_cnt <= '0;
      end else if (r_stab_cnt != CNT_W'(STABLE_CYCLES - 1)) begin
        r_stab_cnt <= r_stab_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_adj   <= '0;
      r_reach <= '0;
      r_step  <= '0;
    end else if (r_state == IDLE && w_next == CLOSE) begin
      r_adj   <= w_m;
      r_reach <= w_m;
      r_step  <= '0;
    end else if (r_state == CLOSE) begin
      r_reach <= w_reach_next;
      r_step  <= r_step + STEP_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dl_detect  <= 1'b0;
      r_dl_members <= '0;
      r_dl_origin  <= '0;
    end else if (bus.clear) begin
      r_dl_detect  <= 1'b0;
      r_dl_members <= '0;
      r_dl_origin  <= '0;
    end else if (r_state == CHECK && w_next == LOCKED) begin
      r_dl_detect  <= 1'b1;
      r_dl_members <= w_diag;
      r_dl_origin  <= IDX_W'(lowest_set(MAX_PROC'(w_diag)));
    end
  end

`ifdef DL_TIMESTAMP_EN
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_dl_cycle;

  // Stamp is the number of edges since reset release, detection edge included.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cyc_cnt  <= '0;
      r_dl_cycle <= '0;
    end else begin
      r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if (bus.clear) r_dl_cycle <= '0;
      else if (r_state == CHECK && w_next == LOCKED) r_dl_cycle <= r_cyc_cnt + 32'd1;
    end
  end

  assign bus.dl_cycle = r_dl_cycle;
`endif

  assign bus.busy       = w_busy;
  assign bus.dl_detect  = r_dl_detect;
  assign bus.dl_members = r_dl_members;
  assign bus.dl_origin  = r_dl_origin;

endmodule
